// File: rtl/axis_iic_pkg.sv
// Shared definitions for the AXI-Stream I2C target.
//   iic_state_t : protocol FSM states
//   SDA_ACK     : SDA level for acknowledge (line pulled low)
//   SDA_NACK    : SDA level for not-acknowledge / released line
package axis_iic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } iic_state_t;

  localparam logic SDA_ACK  = 1'b0;
  localparam logic SDA_NACK = 1'b1;

endpackage

// File: rtl/iic_line_filter.sv
// Input conditioning for one I2C line: 2-flop synchronizer followed by a
// glitch filter. The filtered level only changes after FILTER_LEN consecutive
// synchronized samples disagree with it (latency 2+FILTER_LEN cycles).
//   clk, reset : clock, asynchronous active-high reset (line idles high)
//   line_i     : raw line level
//   line_o     : synchronized, filtered line level
module iic_line_filter #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic line_i,
  output logic line_o
);

  logic       sync_1;
  logic       sync_2;
  logic [3:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
      line_o <= 1'b1;
      cnt    <= '0;
    end else begin
      sync_1 <= line_i;
      sync_2 <= sync_1;
      if (sync_2 != line_o) begin
        if (cnt == 4'(FILTER_LEN - 1)) begin
          line_o <= sync_2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/axis_iic_target.sv
// I2C target bridging bus writes to an AXI-Stream master port and bus reads
// from an AXI-Stream slave port. No clock stretching.
//   clk, reset          : clock, asynchronous active-high reset
//   scl_i, sda_i        : raw bus line levels
//   scl_t, sda_t        : tristate controls (1 = released, 0 = drive low)
//   m_axis_*            : write bytes from the bus master, tuser = {addr, 0}
//   s_axis_*            : bytes returned on bus reads
//   err_overflow        : pulse when a write byte is NACKed for lack of space
//   err_underrun        : pulse when a read finds no s_axis data (0xFF sent)
module axis_iic_target #(
  parameter logic [6:0]  DEVICE_ADDR = 7'h50,
  parameter int unsigned FILTER_LEN  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_t,
  output logic       sda_t,
  output logic [7:0] m_axis_tdata,
  output logic [7:0] m_axis_tuser,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic       err_overflow,
  output logic       err_underrun
);

  import axis_iic_pkg::*;

  iic_state_t state;
  logic       scl_f, sda_f, scl_d, sda_d;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [2:0] bit_cnt;
  logic       byte_done;
  logic [7:0] shreg;
  logic [7:0] txreg;
  logic [7:0] tx_byte;
  logic       rw;
  logic       mack;
  logic [7:0] pend_data;
  logic       pend_valid;
  logic       flush;
  logic       m_free;
  logic       tx_load;
  logic       wr_done;
  logic       flush_push;

  assign scl_t = 1'b1;

  iic_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk    (clk),
    .reset  (reset),
    .line_i (scl_i),
    .line_o (scl_f)
  );

  iic_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk    (clk),
    .reset  (reset),
    .line_i (sda_i),
    .line_o (sda_f)
  );

  always_comb begin
    scl_rise   = scl_f & ~scl_d;
    scl_fall   = ~scl_f & scl_d;
    start_det  = scl_f & scl_d & sda_d & ~sda_f;
    stop_det   = scl_f & scl_d & ~sda_d & sda_f;
    m_free     = ~m_axis_tvalid | m_axis_tready;
    // The first bit of a read byte goes out on the SCL fall that leaves the
    // ACK slot, so the s_axis word is accepted in that same cycle.
    tx_load    = scl_fall & (((state == ADDR_ACK) & rw) |
                             ((state == RD_ACK) & (mack == SDA_ACK)));
    s_axis_tready = tx_load & s_axis_tvalid;
    tx_byte    = s_axis_tvalid ? s_axis_tdata : 8'hFF;
    wr_done    = (state == WR_DATA) & scl_fall & byte_done;
    flush_push = flush & pend_valid & m_free & ~wr_done;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      scl_d         <= 1'b1;
      sda_d         <= 1'b1;
      bit_cnt       <= 3'd7;
      byte_done     <= 1'b0;
      shreg         <= '0;
      txreg         <= '1;
      rw            <= 1'b0;
      mack          <= SDA_NACK;
      sda_t         <= SDA_NACK;
      pend_data     <= '0;
      pend_valid    <= 1'b0;
      flush         <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      err_overflow  <= 1'b0;
      err_underrun  <= 1'b0;
    end else begin
      scl_d        <= scl_f;
      sda_d        <= sda_f;
      err_overflow <= 1'b0;
      err_underrun <= 1'b0;

      if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;

      if (start_det || stop_det) begin
        state     <= start_det ? ADDR : IDLE;
        bit_cnt   <= 3'd7;
        byte_done <= 1'b0;
        sda_t     <= SDA_NACK;
        if (pend_valid) flush <= 1'b1;
      end else begin
        unique case (state)
          IDLE: ;

          ADDR: begin
            if (scl_rise) begin
              shreg <= {shreg[6:0], sda_f};
              if (bit_cnt == 3'd0) byte_done <= 1'b1;
              else bit_cnt <= bit_cnt - 3'd1;
            end else if (scl_fall && byte_done) begin
              byte_done <= 1'b0;
              bit_cnt   <= 3'd7;
              if (shreg[7:1] == DEVICE_ADDR) begin
                state <= ADDR_ACK;
                sda_t <= SDA_ACK;
                rw    <= shreg[0];
              end else begin
                state <= IGNORE;
              end
            end
          end

          ADDR_ACK: begin
            if (scl_fall) begin
              if (rw) begin
                state        <= RD_DATA;
                sda_t        <= tx_byte[7];
                txreg        <= {tx_byte[6:0], 1'b1};
                err_underrun <= ~s_axis_tvalid;
              end else begin
                state <= WR_DATA;
                sda_t <= SDA_NACK;
              end
            end
          end

          WR_DATA: begin
            if (scl_rise) begin
              shreg <= {shreg[6:0], sda_f};
              if (bit_cnt == 3'd0) byte_done <= 1'b1;
              else bit_cnt <= bit_cnt - 3'd1;
            end else if (wr_done) begin
              byte_done <= 1'b0;
              bit_cnt   <= 3'd7;
              // A new byte can only be held if the previous one moves to the
              // output register now; a stale flush marks it as the last one.
              if (!pend_valid || m_free) begin
                state      <= WR_ACK;
                sda_t      <= SDA_ACK;
                pend_data  <= shreg;
                pend_valid <= 1'b1;
                flush      <= 1'b0;
                if (pend_valid) begin
                  m_axis_tdata  <= pend_data;
                  m_axis_tuser  <= {DEVICE_ADDR, 1'b0};
                  m_axis_tlast  <= flush;
                  m_axis_tvalid <= 1'b1;
                end
              end else begin
                state        <= IGNORE;
                err_overflow <= 1'b1;
              end
            end
          end

          WR_ACK: begin
            if (scl_fall) begin
              state <= WR_DATA;
              sda_t <= SDA_NACK;
            end
          end

          RD_DATA: begin
            if (scl_rise) begin
              if (bit_cnt == 3'd0) byte_done <= 1'b1;
              else bit_cnt <= bit_cnt - 3'd1;
            end else if (scl_fall) begin
              if (byte_done) begin
                byte_done <= 1'b0;
                bit_cnt   <= 3'd7;
                state     <= RD_ACK;
                sda_t     <= SDA_NACK;
              end else begin
                sda_t <= txreg[7];
                txreg <= {txreg[6:0], 1'b1};
              end
            end
          end

          RD_ACK: begin
            if (scl_rise) begin
              mack <= sda_f;
            end else if (scl_fall) begin
              if (mack == SDA_ACK) begin
                state        <= RD_DATA;
                sda_t        <= tx_byte[7];
                txreg        <= {tx_byte[6:0], 1'b1};
                err_underrun <= ~s_axis_tvalid;
              end else begin
                state <= IGNORE;
                sda_t <= SDA_NACK;
              end
            end
          end

          IGNORE: ;

          default: state <= IDLE;
        endcase
      end

      // Held byte closing a transfer goes out as soon as the output is free.
      if (flush_push) begin
        m_axis_tdata  <= pend_data;
        m_axis_tuser  <= {DEVICE_ADDR, 1'b0};
        m_axis_tlast  <= 1'b1;
        m_axis_tvalid <= 1'b1;
        pend_valid    <= 1'b0;
        flush         <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_iic_target.sv
module tb_axis_iic_target;

  localparam int Q = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       scl_t, sda_t;
  logic [7:0] m_axis_tdata, m_axis_tuser;
  logic       m_axis_tvalid, m_axis_tlast;
  logic       m_axis_tready = 1'b0;
  logic [7:0] s_axis_tdata = 8'h00;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic       err_overflow, err_underrun;

  int checks = 0;
  int failures = 0;

  logic [7:0] s_q[$];
  logic [7:0] mq_data[$];
  logic [7:0] mq_user[$];
  logic       mq_last[$];
  int ovf_cnt = 0, und_cnt = 0, sda_low_cnt = 0, s_pops = 0, s_rdy_cnt = 0;

  assign sda_line = sda_m & sda_t;

  always #5 clk = ~clk;

  axis_iic_target #(.DEVICE_ADDR(7'h50), .FILTER_LEN(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .scl_i         (scl_m),
    .sda_i         (sda_line),
    .scl_t         (scl_t),
    .sda_t         (sda_t),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .err_overflow  (err_overflow),
    .err_underrun  (err_underrun)
  );

  // Mid-cycle observation of handshakes and pulses.
  always @(negedge clk) begin
    if (m_axis_tvalid && m_axis_tready) begin
      mq_data.push_back(m_axis_tdata);
      mq_user.push_back(m_axis_tuser);
      mq_last.push_back(m_axis_tlast);
    end
    if (err_overflow) ovf_cnt++;
    if (err_underrun) und_cnt++;
    if (!sda_t) sda_low_cnt++;
    if (s_axis_tready) s_rdy_cnt++;
  end

  // s_axis source fed from s_q.
  always begin
    logic hs;
    @(negedge clk);
    hs = s_axis_tvalid && s_axis_tready;
    if (hs) s_pops++;
    @(posedge clk);
    #1;
    if (hs) void'(s_q.pop_front());
    s_axis_tvalid = (s_q.size() != 0);
    s_axis_tdata  = (s_q.size() != 0) ? s_q[0] : 8'h00;
  end

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic write_bit(input logic b, input logic glitch);
    sda_m = b; tick(Q);
    scl_m = 1'b1;
    if (glitch) begin
      tick(8); sda_m = ~b; tick(2); sda_m = b; tick(2 * Q - 10);
    end else begin
      tick(2 * Q);
    end
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    b = sda_line; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i], i == glitch_bit);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(ack, 1'b0);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    int base, ovf0, und0, pop0, rdy0, low0;

    // Reset state
    tick(5);
    check1("rst_sda_t", sda_t, 1'b1);
    check1("rst_scl_t", scl_t, 1'b1);
    check1("rst_m_tvalid", m_axis_tvalid, 1'b0);
    check1("rst_m_tlast", m_axis_tlast, 1'b0);
    check8("rst_m_tdata", m_axis_tdata, 8'h00);
    check8("rst_m_tuser", m_axis_tuser, 8'h00);
    check1("rst_s_tready", s_axis_tready, 1'b0);
    check1("rst_err_ovf", err_overflow, 1'b0);
    check1("rst_err_und", err_underrun, 1'b0);
    reset = 1'b0;
    tick(20);

    // Write 0x11, 0x22 to address 0x50
    m_axis_tready = 1'b1;
    base = mq_data.size();
    i2c_start();
    write_byte(8'hA0, -1, ack); check1("wr_addr_ack", ack, 1'b0);
    write_byte(8'h11, -1, ack); check1("wr_b0_ack", ack, 1'b0);
    write_byte(8'h22, -1, ack); check1("wr_b1_ack", ack, 1'b0);
    i2c_stop();
    tick(50);
    check_int("wr_beats", mq_data.size() - base, 2);
    if (mq_data.size() >= base + 2) begin
      check8("wr_d0", mq_data[base], 8'h11);
      check1("wr_l0", mq_last[base], 1'b0);
      check8("wr_u0", mq_user[base], 8'hA0);
      check8("wr_d1", mq_data[base + 1], 8'h22);
      check1("wr_l1", mq_last[base + 1], 1'b1);
      check8("wr_u1", mq_user[base + 1], 8'hA0);
    end

    // Read two preloaded bytes, ACK then NACK
    s_q.push_back(8'h5A);
    s_q.push_back(8'hC3);
    tick(5);
    pop0 = s_pops; rdy0 = s_rdy_cnt; und0 = und_cnt;
    i2c_start();
    write_byte(8'hA1, -1, ack); check1("rd_addr_ack", ack, 1'b0);
    read_byte(1'b0, d); check8("rd_b0", d, 8'h5A);
    read_byte(1'b1, d); check8("rd_b1", d, 8'hC3);
    i2c_stop();
    tick(20);
    check_int("rd_pops", s_pops - pop0, 2);
    check_int("rd_tready_cycles", s_rdy_cnt - rdy0, 2);
    check_int("rd_no_underrun", und_cnt - und0, 0);

    // Address mismatch
    base = mq_data.size(); low0 = sda_low_cnt;
    i2c_start();
    write_byte(8'h42, -1, ack); check1("mm_addr_nack", ack, 1'b1);
    write_byte(8'h99, -1, ack); check1("mm_data_nack", ack, 1'b1);
    i2c_stop();
    tick(50);
    check_int("mm_sda_low_cycles", sda_low_cnt - low0, 0);
    check_int("mm_beats", mq_data.size() - base, 0);
    check1("mm_m_tvalid", m_axis_tvalid, 1'b0);

    // Overflow with m_axis stalled
    m_axis_tready = 1'b0;
    base = mq_data.size(); ovf0 = ovf_cnt;
    i2c_start();
    write_byte(8'hA0, -1, ack); check1("ov_addr_ack", ack, 1'b0);
    write_byte(8'h01, -1, ack); check1("ov_b0_ack", ack, 1'b0);
    write_byte(8'h02, -1, ack); check1("ov_b1_ack", ack, 1'b0);
    write_byte(8'h03, -1, ack); check1("ov_b2_nack", ack, 1'b1);
    i2c_stop();
    tick(20);
    check_int("ov_err_pulses", ovf_cnt - ovf0, 1);
    check1("ov_stall_tvalid", m_axis_tvalid, 1'b1);
    check8("ov_stall_tdata", m_axis_tdata, 8'h01);
    check1("ov_stall_tlast", m_axis_tlast, 1'b0);
    m_axis_tready = 1'b1;
    tick(20);
    check_int("ov_beats", mq_data.size() - base, 2);
    if (mq_data.size() >= base + 2) begin
      check8("ov_d0", mq_data[base], 8'h01);
      check1("ov_l0", mq_last[base], 1'b0);
      check8("ov_d1", mq_data[base + 1], 8'h02);
      check1("ov_l1", mq_last[base + 1], 1'b1);
    end

    // Underrun on empty s_axis
    und0 = und_cnt; pop0 = s_pops;
    i2c_start();
    write_byte(8'hA1, -1, ack); check1("ur_addr_ack", ack, 1'b0);
    read_byte(1'b1, d); check8("ur_data", d, 8'hFF);
    i2c_stop();
    tick(20);
    check_int("ur_err_pulses", und_cnt - und0, 1);
    check_int("ur_pops", s_pops - pop0, 0);

    // 2-cycle SDA glitch while SCL high must not look like STOP/START
    base = mq_data.size();
    i2c_start();
    write_byte(8'hA0, -1, ack); check1("gl_addr_ack", ack, 1'b0);
    write_byte(8'h11, 7, ack);  check1("gl_data_ack", ack, 1'b0);
    i2c_stop();
    tick(50);
    check_int("gl_beats", mq_data.size() - base, 1);
    if (mq_data.size() >= base + 1) begin
      check8("gl_d0", mq_data[base], 8'h11);
      check1("gl_l0", mq_last[base], 1'b1);
    end

    // Reset during bit 3 of a write with a byte waiting on m_axis
    m_axis_tready = 1'b0;
    i2c_start();
    write_byte(8'hA0, -1, ack); check1("rs_addr_ack", ack, 1'b0);
    write_byte(8'h33, -1, ack); check1("rs_b0_ack", ack, 1'b0);
    write_byte(8'h44, -1, ack); check1("rs_b1_ack", ack, 1'b0);
    tick(5);
    check1("rs_pre_tvalid", m_axis_tvalid, 1'b1);
    check8("rs_pre_tdata", m_axis_tdata, 8'h33);
    write_bit(1'b1, 1'b0);
    write_bit(1'b0, 1'b0);
    write_bit(1'b0, 1'b0);
    write_bit(1'b0, 1'b0);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    reset = 1'b1;
    #1;
    check1("rs_sda_t", sda_t, 1'b1);
    check1("rs_m_tvalid", m_axis_tvalid, 1'b0);
    scl_m = 1'b0; tick(Q);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    reset = 1'b0;
    base = mq_data.size();
    m_axis_tready = 1'b1;
    tick(Q);
    check_int("rs_discarded", mq_data.size() - base, 0);
    i2c_start();
    write_byte(8'hA0, -1, ack); check1("rs_new_addr_ack", ack, 1'b0);
    write_byte(8'h55, -1, ack); check1("rs_new_b0_ack", ack, 1'b0);
    i2c_stop();
    tick(50);
    check_int("rs_new_beats", mq_data.size() - base, 1);
    if (mq_data.size() >= base + 1) begin
      check8("rs_new_d0", mq_data[base], 8'h55);
      check1("rs_new_l0", mq_last[base], 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
